// File: rtl/plot_pkg.sv
// -----------------------------------------------------------------------------
// plot_pkg
// Shared definitions for the box plotting path: screen geometry, coordinate
// and colour widths, colour constants and the box_fill_plotter state codes.
// No ports (package).
// -----------------------------------------------------------------------------
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // Box offsets never exceed 15 (BOX_W/BOX_H are limited to 1..16).
  localparam int SCAN_W   = 4;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [X_W-1:0]      coord_x_t;
  typedef logic [Y_W-1:0]      coord_y_t;
  typedef logic [SCAN_W-1:0]   scan_t;

  localparam colour_t COL_BLUE  = 3'b001;
  localparam colour_t COL_BLACK = 3'b000;

  // box_fill_plotter FSM encoding, kept as plain constants so the state
  // register stays a bare vector for older tools and scripts.
  typedef logic [1:0] box_state_t;
  localparam box_state_t ST_IDLE = 2'd0;
  localparam box_state_t ST_DRAW = 2'd1;
  localparam box_state_t ST_DONE = 2'd2;

  // True when an unwrapped (one bit wider) coordinate lies on the screen.
  function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < (X_W+1)'(SCREEN_W)) && (y < (Y_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/box_fill_plotter_if.sv
// -----------------------------------------------------------------------------
// box_fill_plotter_if
// Box request handshake between a plot sequencer (master) and the
// box_fill_plotter (slave).
//   req_valid  master->slave  request present
//   req_ready  slave->master  request can be accepted this cycle
//   req_x      master->slave  box top-left x (0..159)
//   req_y      master->slave  box top-left y (0..119)
//   req_colour master->slave  box colour
// -----------------------------------------------------------------------------
interface box_fill_plotter_if;
  import plot_pkg::*;

  logic     req_valid;
  logic     req_ready;
  coord_x_t req_x;
  coord_y_t req_y;
  colour_t  req_colour;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready
  );

endinterface

// File: rtl/box_scan_counter.sv
// -----------------------------------------------------------------------------
// box_scan_counter
// Raster-order pixel offset counter for one box: dx runs 0..BOX_W-1 and
// wraps into dy, which runs 0..BOX_H-1.
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   clear    in   restart at offset (0,0)
//   advance  in   step to the next pixel in raster order
//   dx       out  current column offset
//   dy       out  current row offset
//   last     out  high while at offset (BOX_W-1, BOX_H-1)
// -----------------------------------------------------------------------------
module box_scan_counter
  import plot_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  advance,
  output scan_t dx,
  output scan_t dy,
  output logic  last
);

  localparam scan_t DX_LAST = SCAN_W'(BOX_W - 1);
  localparam scan_t DY_LAST = SCAN_W'(BOX_H - 1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      if (dx == DX_LAST) begin
        dx <= '0;
        dy <= (dy == DY_LAST) ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

  assign last = (dx == DX_LAST) && (dy == DY_LAST);

endmodule

// File: rtl/box_fill_plotter.sv
// -----------------------------------------------------------------------------
// box_fill_plotter
// Accepts one box request per handshake and expands it into BOX_W x BOX_H
// pixel writes toward the VGA adapter, raster order, one pixel per unstalled
// cycle, followed by a one-cycle done pulse.
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   req_if      slave box request handshake (valid/ready, x, y, colour)
//   stall       in   adapter back-pressure; freezes drawing
//   vga_x       out  pixel x
//   vga_y       out  pixel y
//   vga_colour  out  pixel colour
//   vga_plot    out  pixel write strobe
//   busy        out  request in progress
//   done        out  one-cycle pulse after the last pixel of a box
// Build option: define BOX_CLIP_EN to suppress vga_plot for pixels that fall
// off the 160x120 screen (timing is unchanged). Without it every pixel is
// plotted with wrapped coordinates.
// -----------------------------------------------------------------------------
module box_fill_plotter
  import plot_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic                clk,
  input  logic                reset,
  box_fill_plotter_if.slave   req_if,
  input  logic                stall,
  output coord_x_t            vga_x,
  output coord_y_t            vga_y,
  output colour_t             vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  box_state_t state;

  // Captured request
  coord_x_t bx;
  coord_y_t by;
  colour_t  bc;

  scan_t dx;
  scan_t dy;
  logic  last;
  logic  accept;
  logic  advance;
  logic  pix_on;

  assign req_if.req_ready = (state == ST_IDLE);
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign advance          = (state == ST_DRAW) && !stall;

  box_scan_counter #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .dx      (dx),
    .dy      (dy),
    .last    (last)
  );

`ifdef BOX_CLIP_EN
  // Sums kept one bit wider so an off-screen pixel is seen before wrapping.
  logic [X_W:0] px_wide;
  logic [Y_W:0] py_wide;
  assign px_wide = {1'b0, bx} + (X_W+1)'(dx);
  assign py_wide = {1'b0, by} + (Y_W+1)'(dy);
  assign pix_on  = on_screen(px_wide, py_wide);
`else
  assign pix_on  = 1'b1;
`endif

  // NOTE: the capture registers carry no reset; they are only read in DRAW,
  // which can only be entered through an accept that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      bx <= req_if.req_x;
      by <= req_if.req_y;
      bc <= req_if.req_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= COL_BLACK;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes default low; each state raises only what it owns.
      vga_plot <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= accept;
          if (accept) begin
            state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          busy <= 1'b1;
          // A stalled cycle leaves coordinates, counters and state frozen,
          // so the pending pixel is emitted once the stall lifts.
          if (!stall) begin
            vga_x      <= bx + X_W'(dx);
            vga_y      <= by + Y_W'(dy);
            vga_colour <= bc;
            vga_plot   <= pix_on;
            if (last) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
